adder_serial_pw: RTL and testbench



---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_digit.sv | 29 ++
 rtl/adder_serial_pw.sv | 145 ++++++++++++++
 tb/tb_adder_serial_pw.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-digit build still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// One DIGIT-wide ripple-carry slice; kept as a separate module so an
// approximate slice can replace it without touching the sequencer.
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/adder_serial_pw.sv
// Digit-serial add/subtract with signed overflow and valid/ready on both sides.
//
//   state | meaning
//   IDLE  | no operands held, ready for a bundle
//   BUSY  | resolving one digit per cycle, LSB first
//   DONE  | result presented; accepts a new bundle in the drain cycle
module adder_serial_pw
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("adder_serial_pw: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] work_next;
    logic             accept;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the top so the first digit lands at bit 0 after NDIG shifts.
    assign work_next = (work_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // out_ready feeds in_ready combinationally so a drain and a new accept share one edge.
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                work_d  = work_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = work_next;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            a_d     = in_a;
            b_d     = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? ~in_cin : in_cin;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_serial_pw.sv
// Scoreboard bench: three builds (DIGIT=4, 8, 1) at WIDTH=8 against an arithmetic model.
module tb_adder_serial_pw;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst       [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] in_a      [3];
    logic [7:0] in_b      [3];
    logic       in_cin    [3];
    logic       in_sub    [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] out_sum   [3];
    logic       out_cout  [3];
    logic       out_ovf   [3];
    logic       rdy_rand  [3];
    int         ndig_v    [3] = '{2, 1, 8};

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    adder_serial_pw #(.WIDTH(8), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .in_sub(in_sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
        .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
    );

    adder_serial_pw #(.WIDTH(8), .DIGIT(8)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .in_sub(in_sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
        .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
    );

    adder_serial_pw #(.WIDTH(8), .DIGIT(1)) u2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]), .in_sub(in_sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum[2]),
        .out_cout(out_cout[2]), .out_ovf(out_ovf[2])
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua, ub, ci, sa, sb, full, r;
        ua = int'(a);
        ub = int'(b);
        ci = cin ? 1 : 0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            full = ua + ub + ci;
            r    = sa + sb + ci;
        end else begin
            full = ua + (255 - ub) + (1 - ci);
            r    = sa - sb - ci;
        end
        e.sum  = 8'(full);
        e.cout = full[8];
        e.ovf  = (r > 127) || (r < -128);
        e.acc  = 0;
        return e;
    endfunction

    function automatic void q_push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic exp_t q_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [dut%0d] @cyc %0d: got 0x%0h, want 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name, input int i);
        n_cmp++;
        n_bad++;
        $display("FAIL %s [dut%0d] @cyc %0d: event did not occur as required", name, i, cyc);
    endtask

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
        exp_t e;
        bit   done;
        done = 1'b0;
        e = model(a, b, cin, sub);
        in_a[i] = a; in_b[i] = b; in_cin[i] = cin; in_sub[i] = sub; in_valid[i] = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                e.acc = cyc + 1;
                q_push(i, e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
        if (!done) fail("accept_timeout", i);
    endtask

    task automatic wait_valid(input int i, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < maxc && !seen; t++) begin
            @(negedge clk);
            seen = out_valid[i];
        end
        if (!seen) fail("valid_timeout", i);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] s, input logic co, input logic ov);
        wait_valid(0, 20);
        check({tag, "_sum"},  0, 32'(out_sum[0]),  32'(s));
        check({tag, "_cout"}, 0, 32'(out_cout[0]), 32'(co));
        check({tag, "_ovf"},  0, 32'(out_ovf[0]),  32'(ov));
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(i, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        for (int t = 0; t < 100 && q_size(i) != 0; t++) @(negedge clk);
        if (q_size(i) != 0) fail("drain_timeout", i);
    endtask

    task automatic directed();
        out_ready[0] = 1'b1;
        send(0, 8'h3C, 8'h45, 1'b1, 1'b0);
        expect_res("add_3c_45", 8'h82, 1'b0, 1'b1);
        send(0, 8'h10, 8'h01, 1'b0, 1'b1);
        expect_res("sub_10_01", 8'h0F, 1'b1, 1'b0);
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        expect_res("wrap_ff_01", 8'h00, 1'b1, 1'b0);
        send(0, 8'h80, 8'h80, 1'b0, 1'b0);
        expect_res("wrap_80_80", 8'h00, 1'b1, 1'b1);

        // Backpressure: result must hold and ignore input pulses.
        out_ready[0] = 1'b0;
        send(0, 8'h55, 8'h22, 1'b0, 1'b0);
        wait_valid(0, 20);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid[0] = (c % 2) == 0;
            in_a[0] = 8'hAA; in_b[0] = 8'h11; in_cin[0] = 1'b1; in_sub[0] = 1'b1;
            @(negedge clk);
            check("bp_valid", 0, 32'(out_valid[0]), 32'd1);
            check("bp_sum",   0, 32'(out_sum[0]),   32'h77);
            check("bp_ready", 0, 32'(in_ready[0]),  32'd0);
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        send(0, 8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check("overlap_valid", 0, 32'(out_valid[0]), 32'd0);
        check("overlap_ready", 0, 32'(in_ready[0]),  32'd0);
        expect_res("overlap_next", 8'h03, 1'b0, 1'b0);

        // Abort mid-BUSY: reset one edge after accept.
        send(0, 8'h5A, 8'h33, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        #1;
        check("abort_valid", 0, 32'(out_valid[0]), 32'd0);
        check("abort_sum",   0, 32'(out_sum[0]),   32'd0);
        check("abort_ready", 0, 32'(in_ready[0]),  32'd1);
        q0.delete();
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        send(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        expect_res("after_abort", 8'h80, 1'b0, 1'b1);
    endtask

    // Monitor: latency on each rising out_valid, data on each output transfer.
    initial begin
        logic prev [3];
        exp_t e;
        for (int i = 0; i < 3; i++) prev[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    prev[i] = 1'b0;
                end else begin
                    if (out_valid[i] && !prev[i]) begin
                        if (q_size(i) == 0) fail("unexpected_valid", i);
                        else begin
                            e = q_front(i);
                            check("latency", i, cyc - e.acc, ndig_v[i]);
                        end
                    end
                    if (out_valid[i] && out_ready[i]) begin
                        if (q_size(i) == 0) fail("unexpected_xfer", i);
                        else begin
                            e = q_pop(i);
                            check("result", i, 32'({out_cout[i], out_ovf[i], out_sum[i]}),
                                  32'({e.cout, e.ovf, e.sum}));
                        end
                    end
                    prev[i] = out_valid[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (rdy_rand[i]) out_ready[i] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
            in_cin[i] = 1'b0; in_sub[i] = 1'b0; out_ready[i] = 1'b0; rdy_rand[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", i, 32'(out_valid[i]), 32'd0);
            check("rst_ready", i, 32'(in_ready[i]),  32'd1);
            check("rst_sum",   i, 32'(out_sum[i]),   32'd0);
            check("rst_cout",  i, 32'(out_cout[i]),  32'd0);
            check("rst_ovf",   i, 32'(out_ovf[i]),   32'd0);
            rst[i] = 1'b0;
        end
        @(posedge clk); #1;
        rdy_rand[1] = 1'b1;
        rdy_rand[2] = 1'b1;
        fork
            begin
                directed();
                rdy_rand[0] = 1'b1;
                run_random(0, 400);
            end
            run_random(1, 3000);
            run_random(2, 2500);
        join
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        fail("global_timeout", 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
